// File: rtl/qr_tx_word_serializer_if.sv
// Word handshake between the digital core and the quarter-rate TX serializer.
// The core drives in_data/in_valid; the serializer answers with in_ready.
interface qr_tx_word_serializer_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/qr_tx_word_serializer.sv
// Quarter-rate TX word serializer: 16-bit words (core data, PRBS7, fixed pattern
// or idle) are sliced into one 4-bit nibble per clock for the 4:1 output mux.
module qr_tx_word_serializer #(
    parameter int         WORD_W    = 16,
    parameter int         UF_CNT_W  = 8,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [WORD_W-1:0]      pat,
    qr_tx_word_serializer_if.slave in_if,
    input  logic                   clr_uf,
    output logic [3:0]             dout,
    output logic [UF_CNT_W-1:0]    underflow_cnt
);

    typedef enum logic [1:0] {
        MODE_DATA = 2'd0,
        MODE_PRBS = 2'd1,
        MODE_PAT  = 2'd2,
        MODE_IDLE = 2'd3
    } mode_e;

    localparam logic [UF_CNT_W-1:0] UF_ONE = UF_CNT_W'(1);

    logic [1:0]          phase_q, phase_d;
    logic [WORD_W-1:0]   shifter_q, shifter_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [UF_CNT_W-1:0] uf_q, uf_d;
    logic [6:0]          prbs_q, prbs_d;
    mode_e               last_mode_q, last_mode_d;

    logic                load;
    logic                in_ready_int;
    logic                uf_inc;
    mode_e               mode_s;
    logic [WORD_W-1:0]   src_word;
    logic [WORD_W-1:0]   prbs_word;
    logic [6:0]          prbs_s;

    // A word slot starts whenever phase wraps; reset parks phase at 3 so the
    // first edge after release is already a load edge.
    assign load         = (phase_q == 2'd3);
    assign in_ready_int = rst_n && !hold_valid_q;
    assign in_if.in_ready = in_ready_int;
    assign dout          = shifter_q[3:0];
    assign underflow_cnt = uf_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case/if tree can leave a value unassigned and infer a latch.
        phase_d      = phase_q + 2'd1;
        shifter_d    = {4'h0, shifter_q[WORD_W-1:4]};
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        uf_d         = uf_q;
        prbs_d       = prbs_q;
        last_mode_d  = last_mode_q;
        uf_inc       = 1'b0;
        src_word     = '0;
        prbs_word    = '0;
        mode_s       = mode_e'(mode);

        // Entering PRBS mode restarts the sequence from the seed.
        prbs_s = (last_mode_q != MODE_PRBS) ? PRBS_SEED : prbs_q;
        for (int i = 0; i < WORD_W; i++) begin
            prbs_word[i] = prbs_s[6] ^ prbs_s[5];
            prbs_s       = {prbs_s[5:0], prbs_word[i]};
        end

        if (load) begin
            unique case (mode_s)
                MODE_DATA: begin
                    if (hold_valid_q) begin
                        src_word     = hold_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        uf_inc = 1'b1;
                    end
                end
                MODE_PRBS: begin
                    src_word = prbs_word;
                    prbs_d   = prbs_s;
                end
                MODE_PAT:  src_word = pat;
                MODE_IDLE: src_word = '0;
            endcase
            shifter_d   = src_word;
            last_mode_d = mode_s;
        end

        // Capture only happens while the hold is empty, so it can never
        // collide with the consume above.
        if (in_if.in_valid && in_ready_int) begin
            hold_d       = in_if.in_data;
            hold_valid_d = 1'b1;
        end

        if (clr_uf) begin
            uf_d = '0;
        end else if (uf_inc && (uf_q != '1)) begin
            uf_d = uf_q + UF_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 2'd3;
            shifter_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            uf_q         <= '0;
            prbs_q       <= PRBS_SEED;
            last_mode_q  <= MODE_IDLE;
        end else begin
            phase_q      <= phase_d;
            shifter_q    <= shifter_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            uf_q         <= uf_d;
            prbs_q       <= prbs_d;
            last_mode_q  <= last_mode_d;
        end
    end

endmodule
